// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the mc_ctrl multi-cycle sequencer and the alu.
// Trap support in mc_ctrl is enabled by defining MC_CTRL_TRAP_EN.
package mc_ctrl_pkg;

  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_OPIMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JAL_JALR = 5'b11011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PCSEL_PLUS4 = 2'b00,
    PCSEL_REL   = 2'b01,
    PCSEL_JALR  = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    WBSEL_ALU  = 2'b00,
    WBSEL_LOAD = 2'b01,
    WBSEL_LINK = 2'b10
  } wb_sel_e;

  typedef enum logic [3:0] {
    CL_ILLEGAL,
    CL_OP,
    CL_OPIMM,
    CL_LOAD,
    CL_STORE,
    CL_LUI,
    CL_AUIPC,
    CL_BRANCH,
    CL_JUMP
  } insn_class_e;

  function automatic logic uses_imm(input insn_class_e c);
    return c inside {CL_OPIMM, CL_LOAD, CL_STORE, CL_LUI, CL_AUIPC};
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier for mc_ctrl: opcode -> class plus legality.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [4:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7,
  output insn_class_e o_class,
  output logic        o_legal
);

  logic w_bad_funct;

  always_comb begin
    o_class = CL_ILLEGAL;
    case (i_opcode)
      OP_OP:       o_class = CL_OP;
      OP_OPIMM:    o_class = CL_OPIMM;
      OP_LOAD:     o_class = CL_LOAD;
      OP_STORE:    o_class = CL_STORE;
      OP_LUI:      o_class = CL_LUI;
      OP_AUIPC:    o_class = CL_AUIPC;
      OP_BRANCH:   o_class = CL_BRANCH;
      OP_JAL_JALR: o_class = CL_JUMP;
      default:     o_class = CL_ILLEGAL;
    endcase
  end

  // In base RV32I instr[30] only distinguishes SUB/SRA and SRAI; anything else is not an instruction.
  assign w_bad_funct = ((i_opcode == OP_OP) && i_funct7 &&
                        (i_funct3 != 3'b000) && (i_funct3 != 3'b101)) ||
                       ((i_opcode == OP_OPIMM) && i_funct7 && (i_funct3 == 3'b001));

  assign o_legal = (o_class != CL_ILLEGAL) && !w_bad_funct;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB) sharing one memory port.
// Define MC_CTRL_TRAP_EN for illegal-opcode and memory-timeout traps.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       taken_branch,
  input  logic       is_jal,
  input  logic       is_jalr,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] pc_sel,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic [2:0] state,
  output logic       trap
);

  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("mc_ctrl: MEM_TIMEOUT must be at least 1");
  end

  state_e      r_state;
  logic        r_jalr;
  insn_class_e w_class;
  logic        w_legal;
  logic        w_is_store;
  logic        w_timeout;

  mc_ctrl_decode u_decode (
    .i_opcode (opcode),
    .i_funct3 (funct3),
    .i_funct7 (funct7),
    .o_class  (w_class),
    .o_legal  (w_legal)
  );

  assign w_is_store = (w_class == CL_STORE);

`ifdef MC_CTRL_TRAP_EN
  localparam bit          TRAP_EN = 1'b1;
  localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT) + 1;

  logic [WAIT_W-1:0] r_wait;
  logic              w_req_state;

  assign w_req_state = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_timeout   = w_req_state && !mem_ready && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (w_req_state && !mem_ready) begin
      r_wait <= r_wait + WAIT_W'(1);
    end else begin
      r_wait <= '0;
    end
  end

  assign trap = (r_state == ST_TRAP);
`else
  localparam bit TRAP_EN = 1'b0;

  assign w_timeout = 1'b0;
  assign trap      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_jalr  <= 1'b0;
    end else begin
      // ALU jump flags win; funct3 only decides when the ALU flags neither.
      if (r_state == ST_EXEC) begin
        r_jalr <= is_jalr || (!is_jal && (funct3 == 3'b000));
      end
      case (r_state)
        ST_IDLE:   r_state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready)      r_state <= ST_DECODE;
          else if (w_timeout) r_state <= ST_TRAP;
        end
        ST_DECODE: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (!w_legal) begin
            r_state <= TRAP_EN ? ST_TRAP : ST_FETCH;
          end else begin
            case (w_class)
              CL_LOAD, CL_STORE: r_state <= ST_MEM;
              CL_BRANCH:         r_state <= ST_FETCH;
              default:           r_state <= ST_WB;
            endcase
          end
        end
        ST_MEM: begin
          if (mem_ready)      r_state <= w_is_store ? ST_FETCH : ST_WB;
          else if (w_timeout) r_state <= ST_TRAP;
        end
        ST_WB:     r_state <= ST_FETCH;
        ST_TRAP:   r_state <= ST_TRAP;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    a_sel    = 1'b0;
    b_sel    = 1'b0;
    pc_sel   = PCSEL_PLUS4;
    wb_sel   = WBSEL_ALU;
    retire   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      ST_EXEC: begin
        if (!w_legal) begin
          pc_we  = !TRAP_EN;
          retire = !TRAP_EN;
        end else begin
          a_sel = (w_class == CL_AUIPC);
          b_sel = uses_imm(w_class);
          if (w_class == CL_BRANCH) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            pc_sel = taken_branch ? PCSEL_REL : PCSEL_PLUS4;
          end
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = w_is_store;
        if (w_is_store && mem_ready) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        if (w_class == CL_LOAD) begin
          wb_sel = WBSEL_LOAD;
        end else if (w_class == CL_JUMP) begin
          wb_sel = WBSEL_LINK;
          pc_sel = r_jalr ? PCSEL_JALR : PCSEL_REL;
        end
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected outputs queued by the driver, compared on negedge.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic       funct7;
  logic       taken_branch;
  logic       is_jal;
  logic       is_jalr;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       ir_we;
  logic       pc_we;
  logic       rf_we;
  logic       a_sel;
  logic       b_sel;
  logic [1:0] pc_sel;
  logic [1:0] wb_sel;
  logic       retire;
  logic [2:0] state;
  logic       trap;

  mc_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .taken_branch (taken_branch),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .rf_we        (rf_we),
    .a_sel        (a_sel),
    .b_sel        (b_sel),
    .pc_sel       (pc_sel),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .state        (state),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       asel;
    logic       ir;
    logic       pcw;
    logic       rfw;
    logic       a;
    logic       b;
    logic [1:0] pcs;
    logic [1:0] wbs;
    logic       ret;
    logic       trp;
  } ov_t;

  ov_t   act;
  ov_t   q_exp[$];
  string q_tag[$];
  ov_t   m_exp;
  string m_tag;
  int    n_checks = 0;
  int    n_errors = 0;

  assign act = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we,
                a_sel, b_sel, pc_sel, wb_sel, retire, trap};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (st,req,we,asel,ir,pcw,rfw,a,b,pcs,wbs,ret,trap)",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q_exp.size() != 0) begin
      m_exp = q_exp.pop_front();
      m_tag = q_tag.pop_front();
      check(m_tag, {14'b0, act}, {14'b0, m_exp});
    end
  end

  function automatic ov_t mk(input state_e s);
    ov_t v;
    v    = '0;
    v.st = s;
    return v;
  endfunction

  // Called at posedge+1: drives mem_ready for the coming cycle and queues its expected outputs.
  task automatic cyc(input string tag, input ov_t e, input logic rdy);
    mem_ready = rdy;
    q_exp.push_back(e);
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run_insn(input string nm, input logic [4:0] op, input logic [2:0] f3,
                          input logic f7, input logic tk, input logic jal, input logic jalr,
                          input int unsigned fw, input int unsigned mw);
    ov_t v;
    opcode       = op;
    funct3       = f3;
    funct7       = f7;
    taken_branch = tk;
    is_jal       = jal;
    is_jalr      = jalr;
    v     = mk(ST_FETCH);
    v.req = 1'b1;
    for (int unsigned i = 0; i < fw; i++) cyc({nm, "_fetch_wait"}, v, 1'b0);
    v.ir = 1'b1;
    cyc({nm, "_fetch"}, v, 1'b1);
    cyc({nm, "_decode"}, mk(ST_DECODE), 1'b1);
    v = mk(ST_EXEC);
    case (op)
      OP_OPIMM, OP_LOAD, OP_STORE: v.b = 1'b1;
      OP_BRANCH: begin
        v.pcw = 1'b1;
        v.ret = 1'b1;
        v.pcs = tk ? 2'b01 : 2'b00;
      end
      OP_OP, OP_JAL_JALR: ;
      default: begin
`ifndef MC_CTRL_TRAP_EN
        v.pcw = 1'b1;
        v.ret = 1'b1;
`endif
      end
    endcase
    cyc({nm, "_exec"}, v, 1'b1);
    if ((op == OP_LOAD) || (op == OP_STORE)) begin
      v      = mk(ST_MEM);
      v.req  = 1'b1;
      v.asel = 1'b1;
      v.we   = (op == OP_STORE);
      for (int unsigned i = 0; i < mw; i++) cyc({nm, "_mem_wait"}, v, 1'b0);
      if (op == OP_STORE) begin
        v.pcw = 1'b1;
        v.ret = 1'b1;
      end
      cyc({nm, "_mem"}, v, 1'b1);
    end
    if ((op == OP_OP) || (op == OP_OPIMM) || (op == OP_LOAD) || (op == OP_JAL_JALR)) begin
      v     = mk(ST_WB);
      v.rfw = 1'b1;
      v.pcw = 1'b1;
      v.ret = 1'b1;
      if (op == OP_LOAD) v.wbs = 2'b01;
      if (op == OP_JAL_JALR) begin
        v.wbs = 2'b10;
        v.pcs = (f3 == 3'b000) ? 2'b10 : 2'b01;
      end
      cyc({nm, "_wb"}, v, 1'b0);
    end
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    check({nm, "_async"}, {14'b0, act}, {14'b0, mk(ST_IDLE)});
    @(posedge clk);
    #1;
    check({nm, "_hold"}, {14'b0, act}, {14'b0, mk(ST_IDLE)});
    rst_n = 1'b1;
    cyc({nm, "_idle"}, mk(ST_IDLE), 1'b0);
  endtask

  initial begin
    ov_t v;
    rst_n        = 1'b0;
    opcode       = '0;
    funct3       = '0;
    funct7       = 1'b0;
    taken_branch = 1'b0;
    is_jal       = 1'b0;
    is_jalr      = 1'b0;
    mem_ready    = 1'b0;
    #1;
    check("reset_state", {14'b0, act}, {14'b0, mk(ST_IDLE)});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("first_idle", mk(ST_IDLE), 1'b1);

    run_insn("add",      OP_OP,       3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_insn("lw",       OP_LOAD,     3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3, 2);
    run_insn("beq_tk",   OP_BRANCH,   3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    run_insn("beq_nt",   OP_BRANCH,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_insn("jalr",     OP_JAL_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    run_insn("jal",      OP_JAL_JALR, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    run_insn("addi",     OP_OPIMM,    3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    run_insn("sw",       OP_STORE,    3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
    run_insn("sub",      OP_OP,       3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

`ifdef MC_CTRL_TRAP_EN
    run_insn("illegal", 5'b11111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    v     = mk(ST_TRAP);
    v.trp = 1'b1;
    for (int i = 0; i < 3; i++) cyc("trap_sticky", v, 1'b1);
    do_reset("trap_reset");
    run_insn("add_w15", OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 15, 0);
    opcode = OP_OP;
    v      = mk(ST_FETCH);
    v.req  = 1'b1;
    for (int i = 0; i < 16; i++) cyc("fetch_timeout_wait", v, 1'b0);
    v     = mk(ST_TRAP);
    v.trp = 1'b1;
    for (int i = 0; i < 2; i++) cyc("timeout_trap", v, 1'b1);
    do_reset("timeout_reset");
`else
    run_insn("illegal_nop", 5'b11111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_insn("add_w20",     OP_OP,    3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 20, 0);
`endif

    // SW interrupted by reset while its MEM access is still waiting
    opcode = OP_STORE;
    funct3 = 3'b010;
    funct7 = 1'b0;
    v      = mk(ST_FETCH);
    v.req  = 1'b1;
    v.ir   = 1'b1;
    cyc("swr_fetch", v, 1'b1);
    cyc("swr_decode", mk(ST_DECODE), 1'b0);
    v   = mk(ST_EXEC);
    v.b = 1'b1;
    cyc("swr_exec", v, 1'b0);
    v      = mk(ST_MEM);
    v.req  = 1'b1;
    v.asel = 1'b1;
    v.we   = 1'b1;
    cyc("swr_mem_wait", v, 1'b0);
    cyc("swr_mem_wait", v, 1'b0);
    mem_ready = 1'b1;
    #2;
    do_reset("swr_reset");
    v     = mk(ST_FETCH);
    v.req = 1'b1;
    cyc("swr_refetch", v, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
